elevator_controller: RTL and testbench

Sequences the car of the three-floor elevator. Latches conditioned floor-call buttons (active-high, post-inversion) into a pending-request register and schedules car motion with a direction-preferring collective algorithm. Times travel and door dwell from an external `tick` enable. Sits between the button conditioning stage and the floor/door display logic; all outputs are registered.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/request_register.sv | 20 ++
 rtl/elevator_controller.sv | 108 ++++++++++
 tb/tb_elevator_controller.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared types, floor limits and pending-request helpers for the elevator controller
package elevator_pkg;
  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  typedef enum logic {UP, DOWN} dir_t;
  localparam logic [1:0] FLOOR_MIN = 2'd1;
  localparam logic [1:0] FLOOR_MAX = 2'd3;
  localparam int NUM_FLOORS = 3;
  function automatic logic [NUM_FLOORS-1:0] floor_mask(input logic [1:0] f);
    return 3'b001 << (f - 2'd1);
  endfunction
  function automatic logic above(input logic [NUM_FLOORS-1:0] p, input logic [1:0] f);
    return |(p >> f);
  endfunction
  function automatic logic below(input logic [NUM_FLOORS-1:0] p, input logic [1:0] f);
    return |(p & (floor_mask(f) - 3'd1));
  endfunction
endpackage

// File: rtl/request_register.sv
// request_register: latches floor calls and drops the served floor while its door is open
module request_register
  import elevator_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] buttons,
  input  logic       clear_en,
  input  logic [1:0] floor,
  output logic [2:0] pending,
  output logic       req_above,
  output logic       req_below
);
  logic [2:0] pending_d, pending_q;
  always_comb pending_d = (pending_q | buttons) & ~(clear_en ? floor_mask(floor) : 3'b000);
  always_ff @(posedge clk) pending_q <= !reset_n ? 3'b000 : pending_d;
  assign pending = pending_q;
  assign req_above = above(pending_q, floor);
  assign req_below = below(pending_q, floor);
endmodule

// File: rtl/elevator_controller.sv
// elevator_controller: direction-preferring collective scheduler for a three-floor car
module elevator_controller
  import elevator_pkg::*;
#(
  parameter int TRAVEL_TICKS = 4,
  parameter int DOOR_TICKS = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  output logic [1:0] floor,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic [2:0] pending
);
  localparam int MAX_TICKS = TRAVEL_TICKS > DOOR_TICKS ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CW = MAX_TICKS > 2 ? $clog2(MAX_TICKS) : 1;
  localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_TICKS - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_TICKS - 1);
  state_t state_d, state_q;
  dir_t dir_d, dir_q;
  logic [1:0] floor_d, floor_q, next_floor;
  logic [CW-1:0] cnt_d, cnt_q;
  logic [2:0] buttons, pending_w;
  logic req_above, req_below, up_q, down_q, door_q;
  assign buttons = {button3, button2, button1};
  request_register u_req (
    .clk(clk),
    .reset_n(reset_n),
    .buttons(buttons),
    .clear_en(state_q == DOOR_OPEN),
    .floor(floor_q),
    .pending(pending_w),
    .req_above(req_above),
    .req_below(req_below)
  );
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    floor_d = floor_q;
    cnt_d = cnt_q;
    next_floor = state_q == MOVE_UP ? floor_q + 2'd1 : floor_q - 2'd1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (|(pending_w & floor_mask(floor_q))) state_d = DOOR_OPEN;
        else if (req_above && (dir_q == UP || !req_below)) begin
          state_d = MOVE_UP;
          dir_d = UP;
        end else if (req_below) begin
          state_d = MOVE_DOWN;
          dir_d = DOWN;
        end
      end
      MOVE_UP, MOVE_DOWN: if (tick) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TRAVEL_LAST) begin
          floor_d = next_floor;
          cnt_d = '0;
          state_d = |(pending_w & floor_mask(next_floor)) ? DOOR_OPEN
                  : (state_q == MOVE_UP ? above(pending_w, next_floor) : below(pending_w, next_floor)) ? state_q
                  : IDLE;
        end
      end
      DOOR_OPEN: begin
        if (|(buttons & floor_mask(floor_q))) cnt_d = '0;
        else if (tick) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == DOOR_LAST) begin
            state_d = IDLE;
            cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dir_q <= UP;
      floor_q <= FLOOR_MIN;
      cnt_q <= '0;
      up_q <= 1'b0;
      down_q <= 1'b0;
      door_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      floor_q <= floor_d;
      cnt_q <= cnt_d;
      up_q <= state_d == MOVE_UP;
      down_q <= state_d == MOVE_DOWN;
      door_q <= state_d == DOOR_OPEN;
    end
  end
  always_ff @(posedge clk)
    if (reset_n) assert (!(state_q == MOVE_UP && floor_q == FLOOR_MAX) && !(state_q == MOVE_DOWN && floor_q == FLOOR_MIN));
  assign floor = floor_q;
  assign moving_up = up_q;
  assign moving_down = down_q;
  assign door_open = door_q;
  assign pending = pending_w;
endmodule

// File: tb/tb_elevator_controller.sv
// tb_elevator_controller: directed scenarios plus randomized run against a countdown-based car model
module tb_elevator_controller;
  localparam int TT = 4;
  localparam int DT = 6;
  localparam int S_IDLE = 0, S_UP = 1, S_DN = 2, S_DOOR = 3;
  logic clk = 1'b0, reset_n = 1'b0, tick = 1'b1;
  logic button1 = 1'b0, button2 = 1'b0, button3 = 1'b0;
  logic [1:0] floor;
  logic moving_up, moving_down, door_open;
  logic [2:0] pending;
  int vec = 0, errs = 0;
  int mf = 1, ms = S_IDLE, mleft = 0;
  bit mup = 1'b1;
  bit [3:1] mp = '0;
  always #5 clk = ~clk;
  elevator_controller #(.TRAVEL_TICKS(TT), .DOOR_TICKS(DT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick(tick),
    .button1(button1),
    .button2(button2),
    .button3(button3),
    .floor(floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .pending(pending)
  );
  function automatic bit further(input bit [3:1] p, input int f, input bit up);
    for (int g = 1; g <= 3; g++) if (p[g] && (up ? g > f : g < f)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model(input bit [3:1] b, input bit t, input bit rn);
    bit [3:1] np;
    if (!rn) begin
      mf = 1; ms = S_IDLE; mup = 1'b1; mp = '0; mleft = 0;
      return;
    end
    np = mp | b;
    if (ms == S_DOOR) np[mf] = 1'b0;
    case (ms)
      S_IDLE:
        if (mp[mf]) begin ms = S_DOOR; mleft = DT; end
        else if (further(mp, mf, 1) && (mup || !further(mp, mf, 0))) begin ms = S_UP; mup = 1'b1; mleft = TT; end
        else if (further(mp, mf, 0)) begin ms = S_DN; mup = 1'b0; mleft = TT; end
      S_UP, S_DN:
        if (t) begin
          mleft--;
          if (mleft == 0) begin
            mf += (ms == S_UP) ? 1 : -1;
            if (mp[mf]) begin ms = S_DOOR; mleft = DT; end
            else if (further(mp, mf, ms == S_UP)) mleft = TT;
            else ms = S_IDLE;
          end
        end
      default:
        if (b[mf]) mleft = DT;
        else if (t) begin
          mleft--;
          if (mleft == 0) ms = S_IDLE;
        end
    endcase
    mp = np;
  endtask
  task automatic step(input bit [3:1] b, input bit t = 1'b1, input bit rn = 1'b1);
    {button3, button2, button1} = b;
    tick = t;
    reset_n = rn;
    @(posedge clk);
    model(b, t, rn);
    #1;
  endtask
  task automatic run_until(input logic want, output int n);
    n = 0;
    while (door_open !== want && n < 60) begin
      step(3'b000);
      n++;
    end
  endtask
  function automatic logic [7:0] obs();
    return {floor, moving_up, moving_down, door_open, pending};
  endfunction
  function automatic logic [7:0] exp_vec();
    return {2'(mf), ms == S_UP, ms == S_DN, ms == S_DOOR, mp};
  endfunction
  task automatic test_reset();
    repeat (3) step(3'b000, 1'b1, 1'b0);
    repeat (10) begin
      step(3'b000);
      vec++;
      if (obs() !== 8'b01_000_000) begin errs++; $display("FAIL reset_idle: got %b want %b", obs(), 8'b01_000_000); end
    end
  endtask
  task automatic test_call_up();
    int n;
    step(3'b100);
    vec++;
    if (pending !== 3'b100 || moving_up !== 1'b0) begin errs++; $display("FAIL call_latch: got pending=%b up=%b want 100/0", pending, moving_up); end
    step(3'b000);
    vec++;
    if (moving_up !== 1'b1 || floor !== 2'd1) begin errs++; $display("FAIL call_start: got up=%b floor=%0d want 1/1", moving_up, floor); end
    repeat (3) step(3'b000);
    vec++;
    if (floor !== 2'd1) begin errs++; $display("FAIL travel_early: got floor=%0d want 1", floor); end
    step(3'b000);
    vec++;
    if (floor !== 2'd2 || moving_up !== 1'b1) begin errs++; $display("FAIL travel_f2: got floor=%0d up=%b want 2/1", floor, moving_up); end
    repeat (4) step(3'b000);
    vec++;
    if (floor !== 2'd3 || door_open !== 1'b1 || moving_up !== 1'b0) begin errs++; $display("FAIL arrive_f3: got %b", obs()); end
    run_until(1'b0, n);
    vec++;
    if (n != DT) begin errs++; $display("FAIL door_len: got %0d want %0d", n, DT); end
    vec++;
    if (obs() !== 8'b11_000_000) begin errs++; $display("FAIL after_door: got %b want %b", obs(), 8'b11_000_000); end
  endtask
  task automatic test_stop_between();
    int n;
    step(3'b011);
    vec++;
    if (pending !== 3'b011) begin errs++; $display("FAIL down_latch: got %b want 011", pending); end
    run_until(1'b1, n);
    vec++;
    if (n >= 60 || floor !== 2'd2) begin errs++; $display("FAIL stop_f2: got floor=%0d n=%0d want 2", floor, n); end
    run_until(1'b0, n);
    vec++;
    if (n != DT || pending !== 3'b001) begin errs++; $display("FAIL door_f2: got len=%0d pending=%b want %0d/001", n, pending, DT); end
    run_until(1'b1, n);
    vec++;
    if (n >= 60 || floor !== 2'd1) begin errs++; $display("FAIL stop_f1: got floor=%0d n=%0d want 1", floor, n); end
    run_until(1'b0, n);
    vec++;
    if (obs() !== 8'b01_000_000) begin errs++; $display("FAIL after_f1: got %b want %b", obs(), 8'b01_000_000); end
  endtask
  task automatic test_dir_pref();
    int n;
    step(3'b010);
    run_until(1'b1, n);
    run_until(1'b0, n);
    vec++;
    if (n >= 60 || floor !== 2'd2) begin errs++; $display("FAIL pref_setup: got floor=%0d want 2", floor); end
    step(3'b101);
    step(3'b000);
    vec++;
    if (moving_up !== 1'b1 || moving_down !== 1'b0 || floor !== 2'd2) begin errs++; $display("FAIL pref_up: got %b", obs()); end
    run_until(1'b1, n);
    vec++;
    if (n >= 60 || floor !== 2'd3) begin errs++; $display("FAIL pref_f3: got floor=%0d want 3", floor); end
    run_until(1'b0, n);
    run_until(1'b1, n);
    vec++;
    if (n >= 60 || floor !== 2'd1) begin errs++; $display("FAIL pref_f1: got floor=%0d want 1", floor); end
    run_until(1'b0, n);
  endtask
  task automatic test_door_hold();
    int n;
    step(3'b010);
    run_until(1'b1, n);
    vec++;
    if (n >= 60 || floor !== 2'd2) begin errs++; $display("FAIL hold_arrive: got floor=%0d want 2", floor); end
    repeat (10) begin
      step(3'b010);
      vec++;
      if (door_open !== 1'b1 || pending[1] !== 1'b0) begin errs++; $display("FAIL hold_open: got door=%b pending=%b want 1/x0x", door_open, pending); end
    end
    run_until(1'b0, n);
    vec++;
    if (n != DT || pending !== 3'b000) begin errs++; $display("FAIL hold_release: got len=%0d pending=%b want %0d/000", n, pending, DT); end
  endtask
  task automatic test_reset_mid_move();
    int n;
    step(3'b001);
    run_until(1'b1, n);
    run_until(1'b0, n);
    vec++;
    if (n >= 60 || floor !== 2'd1) begin errs++; $display("FAIL rst_setup: got floor=%0d want 1", floor); end
    step(3'b100);
    step(3'b000);
    step(3'b000);
    step(3'b000);
    vec++;
    if (moving_up !== 1'b1 || floor !== 2'd1) begin errs++; $display("FAIL rst_moving: got %b", obs()); end
    step(3'b000, 1'b1, 1'b0);
    vec++;
    if (obs() !== 8'b01_000_000) begin errs++; $display("FAIL rst_abort: got %b want %b", obs(), 8'b01_000_000); end
    step(3'b000);
    vec++;
    if (obs() !== 8'b01_000_000) begin errs++; $display("FAIL rst_after: got %b want %b", obs(), 8'b01_000_000); end
  endtask
  task automatic test_random();
    bit [3:1] b;
    for (int i = 0; i < 3000; i++) begin
      b = {$urandom_range(7) == 0, $urandom_range(7) == 0, $urandom_range(7) == 0};
      step(b, $urandom_range(3) != 0, $urandom_range(299) != 0);
      vec++;
      if (obs() !== exp_vec()) begin errs++; $display("FAIL random[%0d]: got %b want %b", i, obs(), exp_vec()); end
    end
  endtask
  initial begin
    test_reset();
    test_call_up();
    test_stop_between();
    test_dir_pref();
    test_door_hold();
    test_reset_mid_move();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
